// File: rtl/cs_addsub_seq_pkg.sv
// Shared definitions for the carry-select sequential add/subtract unit.
//   MODE_ADD / MODE_SUB : encodings of the mode input
//   state_t             : controller states (ST_IDLE, ST_BUSY)
package cs_addsub_seq_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage : cs_addsub_seq_pkg

// File: rtl/cs_addsub_seq_slice.sv
// One carry-select slice: both carry hypotheses are summed in parallel and the
// real carry-in only drives the final mux, keeping it off the adder path.
//   a, b  : SLICE-bit slice operands
//   cin   : carry into the slice
//   sum   : SLICE-bit slice result
//   cout  : carry out of the slice
module cs_addsub_seq_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] sum_c0;
  logic [SLICE:0] sum_c1;

  assign sum_c0 = {1'b0, a} + {1'b0, b};
  assign sum_c1 = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, 1'b1};

  assign {cout, sum} = cin ? sum_c1 : sum_c0;

endmodule : cs_addsub_seq_slice

// File: rtl/cs_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract, one SLICE-bit carry-select slice per clock.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : request, sampled only while idle
//   mode       : 0 = add, 1 = subtract (a - b - c_in)
//   a, b, c_in : operands and carry/borrow-in, latched on acceptance
//   busy       : operation in progress
//   done       : one-cycle completion pulse
//   sum        : result, held until the next completion
//   c_out      : raw carry out of MSB (subtract: 1 = no borrow)
//   ovf, zero  : signed overflow, result is zero
module cs_addsub_seq
  import cs_addsub_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, bx_q, work_q, work_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             accept, last;
  int               base;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;

  // Slice selection, next working value and FSM decisions.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    base    = int'(cnt_q) * SLICE;
    // Full result as it will look after this edge; at the last slice this is
    // the final sum, so flags can load in the same edge as the top slice.
    work_d  = work_q;
    work_d[base +: SLICE] = slice_sum;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CW'(NSLICE - 1)) begin
          last    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cs_addsub_seq_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[base +: SLICE]),
    .b    (bx_q[base +: SLICE]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the working register is reset too, so no stale partial result of an
  // aborted operation survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      bx_q    <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        // Subtraction is a + ~b + ~c_in, i.e. a - b - c_in in two's complement.
        a_q     <= a;
        bx_q    <= (mode == MODE_SUB) ? ~b : b;
        carry_q <= (mode == MODE_SUB) ? ~c_in : c_in;
        cnt_q   <= '0;
      end else if (state_q == ST_BUSY) begin
        work_q  <= work_d;
        carry_q <= slice_cout;
        cnt_q   <= cnt_q + CW'(1);
      end
      if (last) begin
        sum   <= work_d;
        c_out <= slice_cout;
        ovf   <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
        zero  <= (work_d == '0);
      end
    end
  end

  assign busy = (state_q == ST_BUSY);

endmodule : cs_addsub_seq

// File: tb/tb_cs_addsub_seq.sv
// Self-checking bench: an 8-bit/4-bit-slice instance for directed and random
// operations, and a default 32-bit instance for the wide and back-to-back case.
module tb_cs_addsub_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit instance
  logic       start8 = 0, mode8 = 0, cin8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       busy8, done8, cout8, ovf8, zero8;
  logic [7:0] sum8;

  cs_addsub_seq #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .c_in(cin8), .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8),
    .ovf(ovf8), .zero(zero8)
  );

  // 32-bit instance, default parameters
  logic        start32 = 0, mode32 = 0, cin32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic        busy32, done32, cout32, ovf32, zero32;
  logic [31:0] sum32;

  cs_addsub_seq dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .mode(mode32), .a(a32), .b(b32),
    .c_in(cin32), .busy(busy32), .done(done32), .sum(sum32), .c_out(cout32),
    .ovf(ovf32), .zero(zero32)
  );

  // Last completed result of each instance; outputs must hold it while busy.
  logic [7:0]  held8  = '0;
  logic [31:0] held32 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: integer add/subtract at width w, flags from ranges.
  task automatic model(input int w, input longint av, input longint bv, input bit sub,
                       input bit cin, output longint rsum, output bit rc,
                       output bit rovf, output bit rzero);
    longint modv = longint'(1) << w;
    longint half = modv / 2;
    longint sa = (av >= half) ? av - modv : av;
    longint sb = (bv >= half) ? bv - modv : bv;
    longint r, sr;
    if (!sub) begin
      r  = av + bv + longint'(cin);
      sr = sa + sb + longint'(cin);
      rc = (r >= modv);
    end else begin
      r  = av - bv - longint'(cin);
      sr = sa - sb - longint'(cin);
      rc = (r >= 0);
    end
    rsum  = (r % modv + modv) % modv;
    rovf  = (sr < -half) || (sr >= half);
    rzero = (rsum == 0);
  endtask

  // Assumes start8/operands are already driven at a negedge; waits for done,
  // scrambles inputs after acceptance, optionally pokes start while busy.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit sub,
                      input bit cin, input bit poke);
    longint es; bit ec, eo, ez;
    int lat = 0;
    model(8, longint'(av), longint'(bv), sub, cin, es, ec, eo, ez);
    @(posedge clk);
    @(negedge clk);
    start8 = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom); cin8 = 1'($urandom);
    if (poke) start8 = 1;
    while (!done8 && lat < 20) begin
      check("busy8_during_op", busy8, 1'b1);
      check("sum8_held", sum8, held8);
      @(negedge clk);
      start8 = 0;
      lat++;
    end
    check("latency8", lat, 2);
    check("sum8", sum8, es[7:0]);
    check("cout8", cout8, ec);
    check("ovf8", ovf8, eo);
    check("zero8", zero8, ez);
    check("busy8_at_done", busy8, 1'b0);
    held8 = es[7:0];
  endtask

  task automatic run32(input logic [31:0] av, input logic [31:0] bv, input bit sub,
                       input bit cin);
    longint es; bit ec, eo, ez;
    int lat = 0;
    model(32, longint'(av), longint'(bv), sub, cin, es, ec, eo, ez);
    @(posedge clk);
    @(negedge clk);
    start32 = 0;
    a32 = $urandom; b32 = $urandom;
    while (!done32 && lat < 40) begin
      check("sum32_held", sum32, held32);
      @(negedge clk);
      lat++;
    end
    check("latency32", lat, 8);
    check("sum32", sum32, es[31:0]);
    check("cout32", cout32, ec);
    check("ovf32", ovf32, eo);
    check("zero32", zero32, ez);
    held32 = es[31:0];
  endtask

  task automatic go8(input logic [7:0] av, input logic [7:0] bv, input bit sub, input bit cin);
    @(negedge clk);
    a8 = av; b8 = bv; mode8 = sub; cin8 = cin; start8 = 1;
  endtask

  initial begin
    logic [7:0] ra, rb;
    bit rm, rc;

    // Reset state
    #1;
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_sum8", sum8, 8'h00);
    check("rst_flags8", {cout8, ovf8, zero8}, 3'b000);
    check("rst_sum32", sum32, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // 1. add with carry-in
    go8(8'hCC, 8'h55, 1'b0, 1'b1);
    run8(8'hCC, 8'h55, 1'b0, 1'b1, 1'b0);
    check("t1_const", {cout8, ovf8, zero8, sum8}, {3'b100, 8'h22});
    @(negedge clk);
    check("t1_done_pulse", done8, 1'b0);

    // 2. subtract with signed overflow
    go8(8'hCC, 8'h55, 1'b1, 1'b0);
    run8(8'hCC, 8'h55, 1'b1, 1'b0, 1'b0);
    check("t2_const", {cout8, ovf8, zero8, sum8}, {3'b110, 8'h77});

    // 3. -128 + -128
    go8(8'h80, 8'h80, 1'b0, 1'b0);
    run8(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    check("t3_const", {cout8, ovf8, zero8, sum8}, {3'b111, 8'h00});

    // 4. start poked while busy is ignored; only one done
    go8(8'h3A, 8'h19, 1'b0, 1'b0);
    run8(8'h3A, 8'h19, 1'b0, 1'b0, 1'b1);
    check("t4_const", sum8, 8'h53);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_no_extra_done", {done8, busy8}, 2'b00);
    end

    // 5. reset mid-operation aborts
    go8(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start8 = 0;
    check("t5_busy_before", busy8, 1'b1);
    rst_n = 0;
    #1;
    check("t5_rst_busy", busy8, 1'b0);
    check("t5_rst_outputs", {done8, cout8, ovf8, zero8, sum8}, 12'h000);
    @(negedge clk);
    rst_n = 1;
    held8 = 8'h00;
    held32 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_done", done8, 1'b0);
    end
    go8(8'h12, 8'h34, 1'b0, 1'b0);
    run8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    check("t5_after_reset", sum8, 8'h46);

    // Randomized operations, some chained back-to-back in the done cycle
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom); rc = 1'($urandom);
      if (n % 3 == 0) begin
        a8 = ra; b8 = rb; mode8 = rm; cin8 = rc; start8 = 1;
      end else begin
        go8(ra, rb, rm, rc);
      end
      run8(ra, rb, rm, rc, 1'($urandom));
    end
    // corner values at 8 bits
    go8(8'h7F, 8'hFF, 1'b1, 1'b0);
    run8(8'h7F, 8'hFF, 1'b1, 1'b0, 1'b0);
    go8(8'h00, 8'h00, 1'b1, 1'b1);
    run8(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    // 6. 32-bit wrap, then a start in the done cycle
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'h1; mode32 = 0; cin32 = 0; start32 = 1;
    run32(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    check("t6_const", {cout32, zero32, sum32}, {2'b11, 32'h0});
    a32 = 32'h8000_0000; b32 = 32'h0000_0001; mode32 = 1; cin32 = 0; start32 = 1;
    run32(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    for (int n = 0; n < 6; n++) begin
      logic [31:0] xa, xb;
      bit xm, xc;
      xa = $urandom; xb = $urandom; xm = 1'($urandom); xc = 1'($urandom);
      a32 = xa; b32 = xb; mode32 = xm; cin32 = xc; start32 = 1;
      run32(xa, xb, xm, xc);
    end
    @(negedge clk);
    check("t6_idle_after", {done32, busy32}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cs_addsub_seq
